// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the UART frame reader (and a future frame transmitter):
// sync byte, error codes and FSM state encoding.
package uart_frame_rx_pkg;

  typedef enum logic [2:0] {
    StHunt = 3'd0,
    StLen  = 3'd1,
    StPay  = 3'd2,
    StChk  = 3'd3,
    StDone = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ErrNone = 2'b00,
    ErrLen  = 2'b01,
    ErrChk  = 2'b10,
    ErrTo   = 2'b11
  } err_code_e;

  localparam logic [7:0] SyncDefault = 8'hA5;

  // A legal LEN is 1..max_len inclusive.
  function automatic logic len_ok(logic [7:0] len, int unsigned max_len);
    return (len != 8'h00) && (len <= 8'(max_len));
  endfunction

endpackage

// File: rtl/uart_frame_rx_timeout_ctr.sv
// Inter-byte idle counter: clears on request, counts while enabled, and pulses expire_o on the
// enabled clock that would take it to Timeout.
module uart_frame_rx_timeout_ctr #(
  parameter int unsigned Timeout = 50000,
  parameter int unsigned ToW     = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [ToW-1:0] cnt_q, cnt_d;

  always_comb begin
    expire_o = enable_i && !clear_i && (cnt_q == ToW'(Timeout - 1));
    cnt_d    = cnt_q;
    if (clear_i || expire_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + ToW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Pops bytes from the UART RX FIFO, deframes SYNC/LEN/payload/CHK packets and holds one good
// payload until the consumer acknowledges it, stalling the FIFO meanwhile.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int unsigned MaxLen  = 8,
  parameter int unsigned LenW    = 4,
  parameter logic [7:0]  Sync    = SyncDefault,
  parameter int unsigned Timeout = 50000,
  parameter int unsigned ToW     = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            rx_empty_i,
  input  logic [7:0]      r_data_i,
  output logic            rd_uart_o,
  output logic            frame_valid_o,
  output logic [LenW-1:0] frame_len_o,
  input  logic [LenW-1:0] rd_addr_i,
  output logic [7:0]      rd_byte_o,
  input  logic            frame_ack_i,
  output logic            err_o,
  output logic [1:0]      err_code_o
);

  state_e          state_q, state_d;
  logic [LenW-1:0] len_q, len_d;
  logic [LenW-1:0] idx_q, idx_d;
  logic [7:0]      chk_q, chk_d;
  logic            frame_valid_q, frame_valid_d;
  logic [LenW-1:0] frame_len_q, frame_len_d;
  logic            err_q, err_d;
  err_code_e       err_code_q, err_code_d;
  logic [7:0]      buf_q [MaxLen];

  logic consume;
  logic in_frame;
  logic buf_we;
  logic to_expire;

  assign consume  = !rx_empty_i && (state_q != StDone);
  assign in_frame = (state_q == StLen) || (state_q == StPay) || (state_q == StChk);
  assign buf_we   = consume && (state_q == StPay);

  uart_frame_rx_timeout_ctr #(
    .Timeout (Timeout),
    .ToW     (ToW)
  ) u_timeout_ctr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (consume || !in_frame),
    .enable_i (in_frame && !consume),
    .expire_o (to_expire)
  );

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    chk_d         = chk_q;
    frame_valid_d = frame_valid_q;
    frame_len_d   = frame_len_q;
    err_d         = 1'b0;
    err_code_d    = err_code_q;

    unique case (state_q)
      StHunt: begin
        if (consume && (r_data_i == Sync)) begin
          state_d = StLen;
        end
      end
      StLen: begin
        if (consume) begin
          if (!len_ok(r_data_i, MaxLen)) begin
            state_d    = StHunt;
            err_d      = 1'b1;
            err_code_d = ErrLen;
          end else begin
            len_d   = r_data_i[LenW-1:0];
            chk_d   = r_data_i;
            idx_d   = '0;
            state_d = StPay;
          end
        end else if (to_expire) begin
          state_d    = StHunt;
          err_d      = 1'b1;
          err_code_d = ErrTo;
        end
      end
      StPay: begin
        if (consume) begin
          chk_d = chk_q ^ r_data_i;
          idx_d = idx_q + LenW'(1);
          if (idx_q == len_q - LenW'(1)) begin
            state_d = StChk;
          end
        end else if (to_expire) begin
          state_d    = StHunt;
          err_d      = 1'b1;
          err_code_d = ErrTo;
        end
      end
      StChk: begin
        if (consume) begin
          if (r_data_i == chk_q) begin
            state_d       = StDone;
            frame_valid_d = 1'b1;
            frame_len_d   = len_q;
          end else begin
            state_d    = StHunt;
            err_d      = 1'b1;
            err_code_d = ErrChk;
          end
        end else if (to_expire) begin
          state_d    = StHunt;
          err_d      = 1'b1;
          err_code_d = ErrTo;
        end
      end
      StDone: begin
        if (frame_ack_i) begin
          state_d       = StHunt;
          frame_valid_d = 1'b0;
          frame_len_d   = '0;
        end
      end
      default: begin
        state_d = StHunt;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StHunt;
      len_q         <= '0;
      idx_q         <= '0;
      chk_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      err_q         <= 1'b0;
      err_code_q    <= ErrNone;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  // Payload storage needs no reset: it is only observable while frame_valid is high.
  always_ff @(posedge clk_i) begin
    if (buf_we) begin
      for (int unsigned i = 0; i < MaxLen; i++) begin
        if (idx_q == LenW'(i)) begin
          buf_q[i] <= r_data_i;
        end
      end
    end
  end

  always_comb begin
    rd_byte_o = 8'h00;
    for (int unsigned i = 0; i < MaxLen; i++) begin
      if ((rd_addr_i == LenW'(i)) && (rd_addr_i < frame_len_q)) begin
        rd_byte_o = buf_q[i];
      end
    end
  end

  assign rd_uart_o     = consume;
  assign frame_valid_o = frame_valid_q;
  assign frame_len_o   = frame_len_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx driven through a show-ahead FIFO model.
module tb_uart_frame_rx;

  localparam int TbTimeout = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic       frame_valid;
  logic [3:0] frame_len;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_byte;
  logic       frame_ack = 1'b0;
  logic       err;
  logic [1:0] err_code;

  logic [7:0] fifo [$];
  int cycle_cnt = 0;
  int last_pop = 0;
  int pops = 0;
  int err_pulses = 0;
  int done_pops = 0;
  int checks = 0;
  int errors = 0;

  uart_frame_rx #(
    .MaxLen  (8),
    .LenW    (4),
    .Sync    (8'hA5),
    .Timeout (TbTimeout),
    .ToW     (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rx_empty_i    (rx_empty),
    .r_data_i      (r_data),
    .rd_uart_o     (rd_uart),
    .frame_valid_o (frame_valid),
    .frame_len_o   (frame_len),
    .rd_addr_i     (rd_addr),
    .rd_byte_o     (rd_byte),
    .frame_ack_i   (frame_ack),
    .err_o         (err),
    .err_code_o    (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle_cnt++;
    if (rd_uart && frame_valid) done_pops++;
    if (rd_uart && !rx_empty && fifo.size() > 0) begin
      void'(fifo.pop_front());
      pops++;
      last_pop = cycle_cnt;
    end
  end

  always @(negedge clk) begin
    rx_empty = (fifo.size() == 0);
    r_data = rx_empty ? 8'h00 : fifo[0];
  end

  always @(negedge clk) begin
    if (err) err_pulses++;
  end

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (frame_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && fifo.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_ack(input int hold);
    @(negedge clk);
    frame_ack = 1'b1;
    repeat (hold) @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_uart, frame_valid, frame_len, err, err_code} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {rd_uart, frame_valid, frame_len, err, err_code});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    bit ok;
    int p0;
    logic [7:0] exp [3];
    exp = '{8'h11, 8'h22, 8'h33};
    p0 = pops;
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h03);
    wait_valid(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL good_valid got 0 want 1"); end
    checks++;
    if (cycle_cnt !== last_pop) begin
      errors++; $display("FAIL good_latency got %0d want %0d", cycle_cnt, last_pop);
    end
    checks++;
    if (pops - p0 !== 6) begin errors++; $display("FAIL good_pops got %0d want 6", pops - p0); end
    checks++;
    if (frame_len !== 4'd3) begin errors++; $display("FAIL good_len got %0d want 3", frame_len); end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_byte !== exp[i]) begin
        errors++; $display("FAIL good_byte%0d got %h want %h", i, rd_byte, exp[i]);
      end
    end
    rd_addr = 4'd3;
    #1;
    checks++;
    if (rd_byte !== 8'h00) begin errors++; $display("FAIL good_oob got %h want 00", rd_byte); end
    checks++;
    if (err_pulses !== 0) begin errors++; $display("FAIL good_noerr got %0d want 0", err_pulses); end
    do_ack(1);
    checks++;
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL good_ack got 1 want 0"); end
  endtask

  task automatic test_bad_chk();
    bit ok;
    int e0;
    e0 = err_pulses;
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h00);
    wait_drain();
    checks++;
    if (err_pulses - e0 !== 1) begin
      errors++; $display("FAIL chk_errcount got %0d want 1", err_pulses - e0);
    end
    checks++;
    if (err_code !== 2'b10) begin errors++; $display("FAIL chk_code got %b want 10", err_code); end
    checks++;
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL chk_novalid got 1 want 0"); end
    push(8'hA5); push(8'h01); push(8'h7E); push(8'h7F);
    wait_valid(30, ok);
    rd_addr = 4'd0;
    #1;
    checks++;
    if (!ok || frame_len !== 4'd1 || rd_byte !== 8'h7E) begin
      errors++; $display("FAIL chk_recover got v=%0d len=%0d b=%h want 1 1 7e", ok, frame_len, rd_byte);
    end
    checks++;
    if (err_code !== 2'b10) begin errors++; $display("FAIL chk_hold got %b want 10", err_code); end
    do_ack(1);
  endtask

  task automatic test_bad_len();
    bit ok;
    int e0;
    e0 = err_pulses;
    push(8'hA5); push(8'h00); push(8'hA5); push(8'h09);
    wait_drain();
    checks++;
    if (err_pulses - e0 !== 2) begin
      errors++; $display("FAIL len_errcount got %0d want 2", err_pulses - e0);
    end
    checks++;
    if (err_code !== 2'b01) begin errors++; $display("FAIL len_code got %b want 01", err_code); end
    push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'h32);
    wait_valid(30, ok);
    rd_addr = 4'd1;
    #1;
    checks++;
    if (!ok || frame_len !== 4'd2 || rd_byte !== 8'h20) begin
      errors++; $display("FAIL len_recover got v=%0d len=%0d b=%h want 1 2 20", ok, frame_len, rd_byte);
    end
    do_ack(1);
  endtask

  task automatic test_garbage();
    bit ok;
    int e0;
    e0 = err_pulses;
    push(8'h00); push(8'hFF); push(8'h5A);
    push(8'hA5); push(8'h02); push(8'hA5); push(8'hA5); push(8'h02);
    wait_valid(40, ok);
    checks++;
    if (!ok || frame_len !== 4'd2) begin
      errors++; $display("FAIL garbage_valid got v=%0d len=%0d want 1 2", ok, frame_len);
    end
    for (int i = 0; i < 2; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_byte !== 8'hA5) begin
        errors++; $display("FAIL garbage_byte%0d got %h want a5", i, rd_byte);
      end
    end
    checks++;
    if (err_pulses !== e0) begin
      errors++; $display("FAIL garbage_silent got %0d want %0d", err_pulses, e0);
    end
    do_ack(1);
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen;
    int e0;
    int p;
    int t_err;
    e0 = err_pulses;
    push(8'hA5); push(8'h04); push(8'h01);
    wait_drain();
    p = last_pop;
    // Arrange for the next byte to be consumed on the last idle clock before expiry.
    for (int i = 0; i < 3 * TbTimeout && cycle_cnt < p + TbTimeout - 2; i++) @(negedge clk);
    @(posedge clk);
    #1;
    push(8'h02);
    repeat (2) @(negedge clk);
    checks++;
    if (last_pop !== p + TbTimeout) begin
      errors++; $display("FAIL to_edge_pop got %0d want %0d", last_pop - p, TbTimeout);
    end
    checks++;
    if (err_pulses !== e0) begin errors++; $display("FAIL to_alive got %0d want %0d", err_pulses, e0); end
    p = last_pop;
    seen = 1'b0;
    t_err = 0;
    for (int i = 0; i < TbTimeout + 20 && !seen; i++) begin
      @(negedge clk);
      if (err) begin seen = 1'b1; t_err = cycle_cnt; end
    end
    checks++;
    if (!seen || t_err !== p + TbTimeout) begin
      errors++; $display("FAIL to_expire got seen=%0d at %0d want at %0d", seen, t_err - p, TbTimeout);
    end
    checks++;
    if (err_code !== 2'b11 || frame_valid !== 1'b0) begin
      errors++; $display("FAIL to_code got %b v=%0d want 11 0", err_code, frame_valid);
    end
    push(8'hA5); push(8'h01); push(8'h55); push(8'h54);
    wait_valid(30, ok);
    rd_addr = 4'd0;
    #1;
    checks++;
    if (!ok || rd_byte !== 8'h55) begin
      errors++; $display("FAIL to_recover got v=%0d b=%h want 1 55", ok, rd_byte);
    end
    do_ack(1);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d0;
    logic [7:0] exp2 [3];
    exp2 = '{8'h0A, 8'h0B, 8'h0C};
    push(8'hA5); push(8'h02); push(8'h01); push(8'h02); push(8'h01);
    push(8'hA5); push(8'h03); push(8'h0A); push(8'h0B); push(8'h0C); push(8'h0E);
    wait_valid(40, ok);
    d0 = done_pops;
    repeat (100) @(negedge clk);
    checks++;
    if (!ok || done_pops !== d0 || rd_uart !== 1'b0 || fifo.size() !== 6) begin
      errors++;
      $display("FAIL b2b_stall got v=%0d pops=%0d rd=%0d q=%0d want 1 0 0 6",
               ok, done_pops - d0, rd_uart, fifo.size());
    end
    rd_addr = 4'd1;
    #1;
    checks++;
    if (frame_len !== 4'd2 || rd_byte !== 8'h02) begin
      errors++; $display("FAIL b2b_first got len=%0d b=%h want 2 02", frame_len, rd_byte);
    end
    do_ack(3);
    wait_valid(40, ok);
    checks++;
    if (!ok || frame_len !== 4'd3) begin
      errors++; $display("FAIL b2b_second got v=%0d len=%0d want 1 3", ok, frame_len);
    end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_byte !== exp2[i]) begin
        errors++; $display("FAIL b2b_byte%0d got %h want %h", i, rd_byte, exp2[i]);
      end
    end
    do_ack(1);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int e0;
    e0 = err_pulses;
    push(8'hA5); push(8'h05); push(8'h01); push(8'h02);
    wait_drain();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_uart, frame_valid, frame_len, err, err_code} !== 9'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got %b want 0", {rd_uart, frame_valid, frame_len, err, err_code});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(8'hA5); push(8'h01); push(8'h33); push(8'h32);
    wait_valid(30, ok);
    rd_addr = 4'd0;
    #1;
    checks++;
    if (!ok || frame_len !== 4'd1 || rd_byte !== 8'h33 || err_pulses !== e0) begin
      errors++;
      $display("FAIL rstmid_recover got v=%0d len=%0d b=%h e=%0d want 1 1 33 0",
               ok, frame_len, rd_byte, err_pulses - e0);
    end
    do_ack(1);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_len();
    test_garbage();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
